// File: rtl/lc4_mem_arbiter.sv
// Round-robin arbiter that shares one fixed-latency memory read port between
// the icache and dcache miss paths and returns each fetched word to its owner.
module lc4_mem_arbiter #(
    parameter int LATENCY = 8,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gwe,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_data,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_done,
    output logic [DW-1:0] d_data,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(LATENCY);

    state_t     state_reg;
    logic [3:0] cnt_reg;
    logic       last_grant_reg;   // 1: dcache was granted most recently

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;

    // A requester whose done is showing this cycle is still holding its stale
    // req; it must not be granted again on the edge that clears its done.
    always_comb begin
        i_elig  = i_req && !i_done;
        d_elig  = d_req && !d_done;
        grant_i = i_elig && (!d_elig || last_grant_reg);
        grant_d = d_elig && (!i_elig || !last_grant_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b1;
            mem_addr       <= '0;
            i_done         <= 1'b0;
            d_done         <= 1'b0;
            i_data         <= '0;
            d_data         <= '0;
            busy           <= 1'b0;
        end else if (gwe) begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_i) begin
                        state_reg      <= BUSY_I;
                        mem_addr       <= i_addr;
                        cnt_reg        <= 4'd0;
                        busy           <= 1'b1;
                        last_grant_reg <= 1'b0;
                    end else if (grant_d) begin
                        state_reg      <= BUSY_D;
                        mem_addr       <= d_addr;
                        cnt_reg        <= 4'd0;
                        busy           <= 1'b1;
                        last_grant_reg <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // mem_data reflects mem_addr once LATENCY edges have passed
                    if (cnt_reg == LAST_CNT) begin
                        if (state_reg == BUSY_I) begin
                            i_data <= mem_data;
                            i_done <= 1'b1;
                        end else begin
                            d_data <= mem_data;
                            d_done <= 1'b1;
                        end
                        busy      <= 1'b0;
                        mem_addr  <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    mem_addr  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc4_mem_arbiter.sv
// Directed bench for lc4_mem_arbiter: stimulus pushes expected done words into a
// scoreboard queue, a negedge monitor pops and compares on every done pulse.
module tb_lc4_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        gwe = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_done;
    logic [15:0] i_data;
    logic        d_req = 1'b0;
    logic [15:0] d_addr = '0;
    logic        d_done;
    logic [15:0] d_data;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit          is_d;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    lc4_mem_arbiter #(.LATENCY(8), .AW(16), .DW(16)) dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_data(i_data),
        .d_req(d_req), .d_addr(d_addr), .d_done(d_done), .d_data(d_data),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // delay_eight_cycles memory model: returns addr^0xAAAA, 8 gwe edges late
    logic [15:0] pipe [8];
    always @(posedge clk) begin
        if (gwe) begin
            pipe[0] <= mem_addr ^ 16'hAAAA;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
    end
    assign mem_data = pipe[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push(input bit is_d, input logic [15:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic grant_tick(input logic [15:0] addr, input string name);
        tick();
        chk({name, "_grant"}, {15'd0, busy, mem_addr}, {15'd0, 1'b1, addr});
    endtask

    // Called just after the grant edge; counts edges until the owner's done shows.
    task automatic run_to_done(input bit is_d, input logic [15:0] addr,
                               input int stall_at, input int stall_len, input string name);
        int n;
        bit got;
        bit hold_ok;
        n = 0;
        got = 0;
        hold_ok = 1;
        while (!got && n < 60) begin
            if (n == stall_at) gwe = 1'b0;
            if (n == stall_at + stall_len) gwe = 1'b1;
            tick();
            n++;
            got = is_d ? d_done : i_done;
            if (!got && (mem_addr !== addr || busy !== 1'b1)) hold_ok = 0;
        end
        gwe = 1'b1;
        chk({name, "_latency"}, n, 9 + stall_len);
        chk({name, "_addr_hold"}, {31'd0, hold_ok}, 32'd1);
        chk({name, "_idle_at_done"}, {15'd0, busy, mem_addr}, 32'd0);
    endtask

    // Monitor: one pop per done pulse, however long gwe stretches it.
    bit i_seen = 0;
    bit d_seen = 0;
    task automatic mon_pop(input bit is_d, input logic [15:0] data);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done: got %s data 0x%0h expected no done", is_d ? "d" : "i", data);
        end else begin
            e = sb.pop_front();
            if (e.is_d != is_d || e.data !== data) begin
                failures++;
                $display("FAIL done_word: got %s 0x%0h expected %s 0x%0h",
                         is_d ? "d" : "i", data, e.is_d ? "d" : "i", e.data);
            end else begin
                $display("ok   done_word: %s 0x%0h", is_d ? "d" : "i", data);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (i_done && !i_seen) mon_pop(1'b0, i_data);
            if (d_done && !d_seen) mon_pop(1'b1, d_data);
            i_seen = i_done;
            d_seen = d_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic [15:0] ia [4] = '{16'h0020, 16'h0021, 16'h0022, 16'h0023};
    logic [15:0] da [4] = '{16'h0030, 16'h0031, 16'h0032, 16'h0033};
    logic [15:0] iw [4] = '{16'hAA8A, 16'hAA8B, 16'hAA88, 16'hAA89};
    logic [15:0] dw [4] = '{16'hAA9A, 16'hAA9B, 16'hAA98, 16'hAA99};

    initial begin
        int ni;
        int nd;
        int ng;
        int t;
        bit order_ok;
        bit prev_busy;
        bit quiet;

        // Reset state
        #2;
        chk("reset_outputs", {6'd0, busy, i_done, d_done, mem_addr},  32'd0);
        chk("reset_data", {i_data, d_data}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {15'd0, busy, mem_addr}, 32'd0);

        // Simultaneous first requests: icache wins, dcache granted on i_done edge
        i_req = 1; i_addr = 16'h0001;
        d_req = 1; d_addr = 16'h0002;
        push(1'b0, 16'hAAAB);
        push(1'b1, 16'hAAA8);
        grant_tick(16'h0001, "sim_i");
        run_to_done(1'b0, 16'h0001, -1, 0, "sim_i");
        i_req = 0;
        grant_tick(16'h0002, "sim_d");
        run_to_done(1'b1, 16'h0002, -1, 0, "sim_d");
        d_req = 0;
        tick();
        chk("sim_done_cleared", {30'd0, i_done, d_done}, 32'd0);

        // Single icache miss
        i_req = 1; i_addr = 16'h0010;
        push(1'b0, 16'hAABA);
        grant_tick(16'h0010, "single_i");
        run_to_done(1'b0, 16'h0010, -1, 0, "single_i");
        chk("single_i_data", {16'd0, i_data}, 32'hAABA);
        i_req = 0;
        tick();

        // gwe stall of 5 cycles mid-transfer, then a stretched done pulse
        d_req = 1; d_addr = 16'h1234;
        push(1'b1, 16'hB89E);
        grant_tick(16'h1234, "stall_d");
        run_to_done(1'b1, 16'h1234, 3, 5, "stall_d");
        d_req = 0;
        gwe = 0;
        tick(); tick();
        chk("done_stretch", {31'd0, d_done}, 32'd1);
        gwe = 1;
        tick();
        chk("done_cleared_after_gwe", {31'd0, d_done}, 32'd0);

        // Sustained contention: both re-request right after each done
        for (int r = 0; r < 4; r++) begin
            push(1'b0, iw[r]);
            push(1'b1, dw[r]);
        end
        i_req = 1; i_addr = ia[0];
        d_req = 1; d_addr = da[0];
        ni = 0; nd = 0; ng = 0; t = 0;
        order_ok = 1;
        prev_busy = 0;
        while ((ni < 4 || nd < 4) && t < 300) begin
            tick();
            t++;
            if (busy && !prev_busy) begin
                if (ng >= 8 || mem_addr !== ((ng % 2 == 0) ? ia[ng/2] : da[ng/2])) order_ok = 0;
                ng++;
            end
            prev_busy = busy;
            if (i_done) begin
                ni++;
                if (ni < 4) i_addr = ia[ni]; else i_req = 0;
            end
            if (d_done) begin
                nd++;
                if (nd < 4) d_addr = da[nd]; else d_req = 0;
            end
        end
        i_req = 0; d_req = 0;
        chk("contention_i_count", ni, 4);
        chk("contention_d_count", nd, 4);
        chk("contention_grant_count", ng, 8);
        chk("contention_grant_order", {31'd0, order_ok}, 32'd1);
        tick();

        // Stale req held through its own done: no re-grant
        i_req = 1; i_addr = 16'h0100;
        push(1'b0, 16'hABAA);
        grant_tick(16'h0100, "stale_i");
        run_to_done(1'b0, 16'h0100, -1, 0, "stale_i");
        tick();
        chk("stale_no_regrant", {15'd0, busy, mem_addr}, 32'd0);
        i_req = 0;
        tick();
        chk("stale_still_idle", {31'd0, busy}, 32'd0);

        // Reset mid-transfer at cnt=4, then a fresh dcache miss
        i_req = 1; i_addr = 16'h00F0;
        grant_tick(16'h00F0, "rst_i");
        tick(); tick(); tick(); tick();
        rst = 1;
        #1;
        chk("rst_async_clear", {15'd0, busy, mem_addr}, 32'd0);
        i_req = 0;
        tick();
        rst = 0;
        quiet = 1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (busy || i_done || d_done) quiet = 0;
        end
        chk("rst_no_done", {31'd0, quiet}, 32'd1);
        d_req = 1; d_addr = 16'h0F0F;
        push(1'b1, 16'hA5A5);
        grant_tick(16'h0F0F, "after_rst_d");
        run_to_done(1'b1, 16'h0F0F, -1, 0, "after_rst_d");
        d_req = 0;
        tick(); tick();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc4_mem_arbiter.md
Name: lc4_mem_arbiter

Overview:
- Shares the single fixed-latency instruction/data memory port between the instruction-cache miss path and the data-cache miss path.
- Each cache raises a request with an address and holds it until this block pulses done with the fetched word.
- The block drives the memory address, counts the pipeline latency of the memory (modelled on the bench by delay_eight_cycles), captures the returned data and routes it to the owner.
- Ties are resolved round-robin.

Parameters:
- LATENCY, 8, number of gwe-qualified cycles between mem_addr becoming stable and mem_data reflecting it (legal 1..14).
- AW, 16, address width.
- DW, 16, data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- gwe  in  1  global write enable; no state changes on edges where gwe=0
- i_req  in  1  icache miss request, held until i_done
- i_addr  in  AW  icache miss address, stable while i_req=1
- i_done  out  1  one-cycle pulse, i_data valid
- i_data  out  DW  fetched word for icache
- d_req  in  1  dcache miss request, held until d_done
- d_addr  in  AW  dcache miss address, stable while d_req=1
- d_done  out  1  one-cycle pulse, d_data valid
- d_data  out  DW  fetched word for dcache
- mem_addr  out  AW  address to memory port
- mem_data  in  DW  memory read data, LATENCY cycles behind mem_addr
- busy  out  1  high while a transfer is in flight

Behaviour:
- All registers update only on rising clk with gwe=1. rst overrides asynchronously.
- Reset values:
  - state=IDLE, cnt=0, last_grant=D (so icache wins the first tie).
  - mem_addr=0, i_done=d_done=0, i_data=d_data=0, busy=0.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, at a gwe edge, with requests eligible:
  - Eligible means req=1 and that requester's done is not high in the current cycle.
  - Only i eligible -> BUSY_I. Only d eligible -> BUSY_D.
  - Both eligible -> grant the requester that is not last_grant.
  - On grant: mem_addr<=requester addr, cnt<=0, busy<=1, last_grant<=grantee.
- BUSY_x: cnt increments every gwe edge. mem_addr is held constant, and the requester's addr is not re-sampled.
- BUSY_x, on the gwe edge where cnt==LATENCY:
  - x_data<=mem_data and x_done<=1 for exactly one cycle.
  - busy<=0, mem_addr<=0, state->IDLE.
- Latency: done rises LATENCY+1 gwe edges after the grant edge (9 cycles at default).
- The done cycle is IDLE. The other requester may be granted on that same edge, so there is no dead cycle.
- A requester still showing req during its own done cycle is ignored for that edge and not re-granted. The requester must drop req after done.
- x_data holds its last captured value until the next capture for x.
- done pulses are cleared on the next gwe edge.
- gwe=0 for any number of cycles: everything freezes.
  - A done pulse stretches until the next gwe edge.
  - Latency is counted only in gwe edges.
- req dropped mid-transfer: the transfer still completes and done still pulses, so the requester must tolerate it.
- rst asserted mid-transfer: the transfer is abandoned, all outputs return to their reset values immediately, and no done is issued.
- cnt is 4 bits wide, so there is no wrap for any legal LATENCY.

Test Plan:
- Single icache miss:
  - Stimulus: i_req=1, i_addr=0x0010, memory model returns addr^0xAAAA.
  - Required: mem_addr=0x0010 from the cycle after grant; i_done pulses 9 cycles after grant with i_data=0xAABA; d_done stays 0.
- Simultaneous first requests:
  - Stimulus: i_req=d_req=1, i_addr=0x0001, d_addr=0x0002.
  - Required: icache granted first, i_data=0xAAAB; the dcache grant happens on the i_done edge, and d_done follows 9 cycles later with d_data=0xAAA8.
- Sustained contention:
  - Stimulus: both requesters re-request immediately after each done, over 4 rounds.
  - Required: grants alternate I,D,I,D; no done is ever lost or duplicated.
- gwe stall:
  - Stimulus: gwe=0 for 5 cycles mid-transfer.
  - Required: done is delayed by exactly 5 cycles; mem_addr stays stable throughout; data is still correct.
- Reset mid-transfer:
  - Stimulus: rst pulses while cnt=4.
  - Required: busy=0 and mem_addr=0 asynchronously; no done pulse; a fresh d_req afterwards completes normally.
- Stale req in done cycle:
  - Stimulus: i_req held high through its own i_done.
  - Required: no second grant to icache on the done edge; the arbiter stays IDLE if d_req=0.
